// File: rtl/div_reconstructor_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the restoring divider and its reconstructor.
//   Holds the default operand widths, the FSM state encoding and a helper
//   that sizes the RUN-step counter.
// ---------------------------------------------------------------------------
package div_pkg;

    // Default datapath widths, shared with the restoring divider.
    localparam int QW = 4;            // quotient width
    localparam int DW = 4;            // divisor / remainder width
    localparam int XW = QW + DW + 1;  // dividend width

    // FSM state encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width able to hold 0..qw.
    function automatic int cnt_width(input int qw);
        return (qw < 1) ? 1 : $clog2(qw + 1);
    endfunction

    localparam int CW = cnt_width(QW);

endpackage

// File: rtl/div_reconstructor_if.sv
// ---------------------------------------------------------------------------
// div_reconstructor_if
//   Operand / result bundle for div_reconstructor.
//   Handshake: the requester raises start with q_in/div_in/rem_in stable; the
//   block takes them on the first rising edge where it is idle (busy=0) and
//   ignores start otherwise. done pulses for one cycle when result/err are
//   valid; result/err then hold until the next done. state_dbg mirrors the
//   internal FSM state for observation.
//
//   start     requester -> block   request
//   q_in      requester -> block   quotient operand   [QW]
//   div_in    requester -> block   divisor operand    [DW]
//   rem_in    requester -> block   remainder operand  [DW]
//   result    block -> requester   rebuilt dividend   [XW]
//   busy      block -> requester   operation in flight
//   done      block -> requester   one-cycle completion pulse
//   err       block -> requester   rem_in >= div_in on the captured operands
//   state_dbg block -> requester   FSM state
// ---------------------------------------------------------------------------
interface div_reconstructor_if #(
    parameter int QW = div_pkg::QW,
    parameter int DW = div_pkg::DW,
    parameter int XW = QW + DW + 1
) ();
    import div_pkg::*;

    logic          start;
    logic [QW-1:0] q_in;
    logic [DW-1:0] div_in;
    logic [DW-1:0] rem_in;
    logic [XW-1:0] result;
    logic          busy;
    logic          done;
    logic          err;
    state_t        state_dbg;

    modport master (
        output start, q_in, div_in, rem_in,
        input  result, busy, done, err, state_dbg
    );

    modport slave (
        input  start, q_in, div_in, rem_in,
        output result, busy, done, err, state_dbg
    );

endinterface

// File: rtl/div_reconstructor.sv
// ---------------------------------------------------------------------------
// div_reconstructor
//   Rebuilds a dividend X = Q*D + R from the outputs of the restoring
//   divider using a sequential shift-and-add multiplier, one quotient bit
//   per clock. The accumulator starts at R so no final add is needed.
//
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    div_reconstructor_if.slave (start/operands in, result/busy/
//          done/err/state_dbg out)
//
//   Timing: accept at edge k, RUN edges k+1..k+QW, done high for the cycle
//   after edge k+QW, back to IDLE at edge k+QW+1.
// ---------------------------------------------------------------------------
module div_reconstructor
    import div_pkg::*;
#(
    parameter int QW = div_pkg::QW,
    parameter int DW = div_pkg::DW,
    parameter int XW = QW + DW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    div_reconstructor_if.slave bus
);

    localparam int CNTW = cnt_width(QW);
    localparam logic [CNTW-1:0] LAST = CNTW'(QW - 1);

    state_t          state_q, state_d;
    logic [XW-1:0]   acc_q, acc_d;
    logic [XW-1:0]   mcand_q, mcand_d;
    logic [QW-1:0]   mplier_q, mplier_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            err_r_q, err_r_d;
    logic [XW-1:0]   result_q, result_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [XW-1:0]   acc_sum;

    // One shift-add step; XW bits always hold the full product plus R.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            err_r_q  <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            err_r_q  <= err_r_d;
            result_q <= result_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        err_r_d  = err_r_q;
        result_d = result_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d    = {{(XW-DW){1'b0}}, bus.rem_in};
                    mcand_d  = {{(XW-DW){1'b0}}, bus.div_in};
                    mplier_d = bus.q_in;
                    count_d  = '0;
                    // A zero divisor also lands here since any R >= 0.
                    err_r_d  = (bus.rem_in >= bus.div_in);
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNTW'(1);
                if (count_q == LAST) begin
                    result_d = acc_sum;
                    err_d    = err_r_q;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.result    = result_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.state_dbg = state_q;

endmodule

// File: doc/div_reconstructor.md
Name: div_reconstructor

Overview:
- Inverse companion to the team's sequential restoring divider (9-bit datapath, 4-bit divisor).
- Takes quotient Q, divisor D and remainder R, and rebuilds the dividend X = Q*D + R with a sequential shift-and-add multiplier.
- Sits after the divider in self-check paths and in the calculator datapath wherever a dividend must be regenerated.
- Start/done handshake; one multiplier bit per clock.

Parameters:
- QW, 4, quotient width in bits (one RUN cycle per bit).
- DW, 4, divisor and remainder width in bits.
- XW, QW+DW+1, result width. Default 9 matches the divider datapath.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request. Sampled only in IDLE.
- q_in  in  QW  quotient operand.
- div_in  in  DW  divisor operand.
- rem_in  in  DW  remainder operand.
- result  out  XW  reconstructed dividend. Registered; held until the next completion.
- busy  out  1  high from the accept edge until the done cycle ends.
- done  out  1  one-cycle pulse when result is valid.
- err  out  1  remainder inconsistent (rem_in >= div_in). Valid with done, held with result.

Behaviour:
- Reset, asynchronous on rst_n low, any state including mid-RUN:
  - state=IDLE.
  - result=0, busy=0, done=0, err=0.
  - Internal acc, mcand, mplier and count cleared.
  - Any in-flight operation is discarded with no done pulse.
  - Operation resumes on the first clk edge after rst_n deasserts.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE, start=1 at edge k (accept):
  - acc <= zero-extended rem_in.
  - mcand <= zero-extended div_in.
  - mplier <= q_in.
  - count <= 0.
  - err_r <= (rem_in >= div_in).
  - busy <= 1; state <= RUN.
  - Operands are captured here; later operand changes have no effect.
- RUN, edges k+1 .. k+QW, one step each:
  - if mplier[0], acc <= acc + mcand (XW-bit add, no truncation).
  - mcand <= mcand << 1.
  - mplier <= mplier >> 1.
  - count <= count + 1.
- On the QW-th RUN edge (k+QW):
  - result <= final acc; err <= err_r.
  - done <= 1; state <= DONE.
- DONE, one cycle:
  - done=1, busy=1.
  - At the next edge: done <= 0, busy <= 0, state <= IDLE.
- Latency: done is visible for exactly one cycle, following edge k+QW (QW+1 edges after the accept edge inclusive).
- start while in RUN or DONE: ignored, not queued. A start held high re-triggers on the first IDLE cycle, which gives back-to-back operation with one idle cycle.
- Width rule: the maximum value, (2^QW-1)(2^DW-1) + 2^DW-1, always fits XW bits. No overflow output.
- div_in=0: result = rem_in; err=1.
- q_in=0: result = rem_in; err follows the rule above.
- result and err change only at the done edge or on reset.

Decomposition:
- Shared package div_pkg:
  - QW/DW/XW defaults, shared with the divider.
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - A count-width constant, clog2(QW+1).
- Single module. The shift-add step is one line and does not justify a sub-module. A separate bench-only reference model, div_reconstructor_model, computes Q*D+R for the scoreboard.

Test Plan:
- q_in=13, div_in=11, rem_in=7, one-cycle start -> done exactly 5 edges after accept; result=150; err=0; busy high for 5 cycles.
- q_in=15, div_in=15, rem_in=14 -> result=239; err=0 (max-value width check).
- q_in=9, div_in=0, rem_in=3 -> result=3; err=1. Then q_in=2, div_in=5, rem_in=5 -> result=15; err=1.
- Accept q_in=6, div_in=7, rem_in=1. Change the operands and pulse start during RUN -> second start ignored; result=43; exactly one done pulse.
- start held high for 3 operations -> done pulses every 6 cycles; each result matches the model; busy low exactly one cycle between operations.
- rst_n low on RUN cycle 2, then start with q_in=3, div_in=4, rem_in=2 -> during reset all outputs=0 with no done; after release result=14.
